interrupt_controller: RTL and testbench

//  Upstream of the processor's 2-bit interrupt input; produces the code that the CSR register file and hazard unit consume.

---
 rtl/intc_pkg.sv | 22 ++
 rtl/irq_sync_edge.sv | 35 +++
 rtl/interrupt_controller.sv | 145 ++++++++++++++
 tb/tb_interrupt_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intc_pkg
// Purpose  : Shared types and constants for the interrupt controller:
//            FSM state encoding and the interrupt code width.
// Revision : 1.0 - initial release
// ============================================================================
package intc_pkg;

    // Arbitration FSM states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;

    // Code presented to the core: 0 = no interrupt, i+1 = source i.
    localparam int                    INT_CODE_W = 2;
    localparam logic [INT_CODE_W-1:0] INT_NONE   = 2'd0;

endpackage : intc_pkg
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_edge
// Purpose  : Brings one asynchronous interrupt source into the clk domain
//            through a SYNC_STAGES flop chain and emits a single-cycle pulse
//            on each synchronised rising edge. A level held high fires once.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    // Synchroniser chain plus one delay flop on the synchronised level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Captures rising edges of asynchronous interrupt sources into a
//            pending register, masks them with a software-written enable,
//            selects one by fixed priority (index 0 highest) and holds its
//            code to the core until acknowledged. After the acknowledge no
//            new request is issued until the core retires mret.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic                  en_wr,
    input  logic [NUM_SRC-1:0]    en_wdata,
    input  logic                  irq_ack,
    input  logic                  mret,
    output logic [INT_CODE_W-1:0] interrupt,
    output logic [NUM_SRC-1:0]    pending,
    output logic [NUM_SRC-1:0]    enable,
    output logic                  in_service
);

    localparam int c_SEL_W = INT_CODE_W;

    logic [NUM_SRC-1:0]    w_rise;
    logic [NUM_SRC-1:0]    w_clr;
    logic [NUM_SRC-1:0]    w_req;
    logic [c_SEL_W-1:0]    w_sel;

    logic [NUM_SRC-1:0]    r_enable;
    logic [NUM_SRC-1:0]    r_pending;
    intc_state_t           r_state;
    logic [c_SEL_W-1:0]    r_sel;
    logic [INT_CODE_W-1:0] r_interrupt;
    logic                  r_in_service;

    // One synchroniser / edge detector per source.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk     (clk),
                .reset   (reset),
                .i_async (irq_src[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    // Enable mask register; masking never touches pending bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable <= '0;
        end else if (en_wr) begin
            r_enable <= en_wdata;
        end
    end

    // Acknowledge clears the latched source's pending bit.
    always_comb begin
        w_clr = '0;
        if (r_state == REQ && irq_ack) begin
            w_clr[r_sel] = 1'b1;
        end
    end

    // Pending register: a new rise wins over a same-cycle acknowledge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    // Fixed-priority encoder: lowest set index of the masked requests wins.
    always_comb begin
        w_req = r_pending & r_enable;
        w_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_sel = c_SEL_W'(i);
            end
        end
    end

    // Request / service FSM with registered code and in_service outputs.
    // The withdraw check reads r_enable, so a same-cycle en_wr is seen late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_interrupt  <= INT_NONE;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_interrupt <= INT_NONE;
                    if (|w_req) begin
                        r_sel       <= w_sel;
                        r_interrupt <= w_sel + c_SEL_W'(1);
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        r_interrupt  <= INT_NONE;
                        r_in_service <= 1'b1;
                        r_state      <= SERVICE;
                    end else if (!r_enable[r_sel]) begin
                        r_interrupt <= INT_NONE;
                        r_state     <= IDLE;
                    end
                end
                SERVICE: begin
                    r_interrupt <= INT_NONE;
                    if (mret) begin
                        r_in_service <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_interrupt  <= INT_NONE;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt  = r_interrupt;
    assign pending    = r_pending;
    assign enable     = r_enable;
    assign in_service = r_in_service;

endmodule : interrupt_controller
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Purpose  : Self-checking bench for interrupt_controller. Expected interrupt
//            codes are queued when stimulus is applied and popped when the
//            core-facing code becomes non-zero; other checks are inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;
    import intc_pkg::*;

    localparam int NUM_SRC = 3;

    logic                  clk;
    logic                  reset;
    logic [NUM_SRC-1:0]    irq_src;
    logic                  en_wr;
    logic [NUM_SRC-1:0]    en_wdata;
    logic                  irq_ack;
    logic                  mret;
    logic [INT_CODE_W-1:0] interrupt;
    logic [NUM_SRC-1:0]    pending;
    logic [NUM_SRC-1:0]    enable;
    logic                  in_service;

    int n_tests = 0;
    int n_fail  = 0;
    logic [INT_CODE_W-1:0] exp_q[$];

    interrupt_controller #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .en_wr      (en_wr),
        .en_wdata   (en_wdata),
        .irq_ack    (irq_ack),
        .mret       (mret),
        .interrupt  (interrupt),
        .pending    (pending),
        .enable     (enable),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_enable(input logic [NUM_SRC-1:0] m);
        en_wr    = 1'b1;
        en_wdata = m;
        tick();
        en_wr    = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    // Scoreboard side: wait (bounded) for a non-zero code, pop and compare.
    task automatic wait_irq(input int budget, input string name);
        logic [INT_CODE_W-1:0] exp;
        int n;
        n = 0;
        while (interrupt == INT_NONE && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: code %0d observed but no expected code queued", name, interrupt);
        end else begin
            exp = exp_q.pop_front();
            if (interrupt !== exp) begin
                n_fail++;
                $display("FAIL %s: interrupt=%0d required %0d (after %0d cycles)", name, interrupt, exp, n);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ticks(3);
        n_tests++;
        if (interrupt !== 2'd0 || pending !== 3'b000 || enable !== 3'b000 || in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: int=%0d pend=%b en=%b insvc=%b required 0/000/000/0",
                     interrupt, pending, enable, in_service);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_latency();
        write_enable(3'b111);
        n_tests++;
        if (enable !== 3'b111) begin
            n_fail++;
            $display("FAIL enable_write: enable=%b required 111", enable);
        end
        irq_src[1] = 1'b1;
        exp_q.push_back(2'd2);
        ticks(3);
        n_tests++;
        if (interrupt !== 2'd0 || pending !== 3'b010) begin
            n_fail++;
            $display("FAIL latency_early: int=%0d pend=%b required 0/010", interrupt, pending);
        end
        tick();
        wait_irq(0, "latency_4_edges");
        ticks(3);
        n_tests++;
        if (interrupt !== 2'd2) begin
            n_fail++;
            $display("FAIL hold_until_ack: interrupt=%0d required 2", interrupt);
        end
        pulse_ack();
        n_tests++;
        if (interrupt !== 2'd0 || in_service !== 1'b1 || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL after_ack: int=%0d insvc=%b pend=%b required 0/1/000",
                     interrupt, in_service, pending);
        end
        irq_src[1] = 1'b0;
        pulse_mret();
        n_tests++;
        if (in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL mret_clears: in_service=%b required 0", in_service);
        end
        ticks(4);
    endtask

    task automatic test_priority();
        irq_src[2] = 1'b1;
        irq_src[0] = 1'b1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        wait_irq(8, "priority_src0");
        pulse_ack();
        ticks(2);
        n_tests++;
        if (interrupt !== 2'd0 || pending !== 3'b100) begin
            n_fail++;
            $display("FAIL no_nesting: int=%0d pend=%b required 0/100", interrupt, pending);
        end
        pulse_mret();
        n_tests++;
        if (interrupt !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_gap: interrupt=%0d required 0", interrupt);
        end
        wait_irq(1, "rearb_src2");
        pulse_ack();
        pulse_mret();
        irq_src = '0;
        ticks(4);
    endtask

    task automatic test_enable_gate();
        write_enable(3'b000);
        irq_src[1] = 1'b1;
        ticks(6);
        n_tests++;
        if (interrupt !== 2'd0 || pending !== 3'b010) begin
            n_fail++;
            $display("FAIL masked_source: int=%0d pend=%b required 0/010", interrupt, pending);
        end
        exp_q.push_back(2'd2);
        write_enable(3'b010);
        wait_irq(1, "unmask_src1");
        pulse_ack();
        pulse_mret();
        irq_src[1] = 1'b0;
        write_enable(3'b111);
        ticks(4);
    endtask

    task automatic test_withdraw();
        irq_src[2] = 1'b1;
        exp_q.push_back(2'd3);
        wait_irq(8, "req_src2");
        write_enable(3'b011);
        n_tests++;
        if (interrupt !== 2'd3) begin
            n_fail++;
            $display("FAIL withdraw_old_enable: interrupt=%0d required 3", interrupt);
        end
        tick();
        n_tests++;
        if (interrupt !== 2'd0 || pending !== 3'b100 || dut.r_state !== IDLE || in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw: int=%0d pend=%b state=%0d insvc=%b required 0/100/IDLE/0",
                     interrupt, pending, dut.r_state, in_service);
        end
        ticks(3);
        n_tests++;
        if (interrupt !== 2'd0) begin
            n_fail++;
            $display("FAIL withdraw_stays: interrupt=%0d required 0", interrupt);
        end
        exp_q.push_back(2'd3);
        write_enable(3'b111);
        wait_irq(2, "reenable_src2");
        pulse_ack();
        pulse_mret();
        irq_src[2] = 1'b0;
        ticks(4);
    endtask

    task automatic test_service_accum();
        irq_src[1] = 1'b1;
        exp_q.push_back(2'd2);
        wait_irq(8, "svc_src1");
        pulse_ack();
        irq_src[0] = 1'b1;
        ticks(5);
        n_tests++;
        if (interrupt !== 2'd0 || pending !== 3'b001 || in_service !== 1'b1) begin
            n_fail++;
            $display("FAIL svc_accumulate: int=%0d pend=%b insvc=%b required 0/001/1",
                     interrupt, pending, in_service);
        end
        exp_q.push_back(2'd1);
        pulse_mret();
        n_tests++;
        if (interrupt !== 2'd0) begin
            n_fail++;
            $display("FAIL svc_mret_gap: interrupt=%0d required 0", interrupt);
        end
        wait_irq(1, "svc_then_src0");
        pulse_ack();
        pulse_mret();
        irq_src = '0;
        ticks(4);
    endtask

    task automatic test_async_reset();
        irq_src[0] = 1'b1;
        exp_q.push_back(2'd1);
        wait_irq(8, "pre_reset_req");
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (interrupt !== 2'd0 || pending !== 3'b000 || enable !== 3'b000 || in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: int=%0d pend=%b en=%b insvc=%b required 0/000/000/0",
                     interrupt, pending, enable, in_service);
        end
        irq_src = '0;
        ticks(2);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset    = 1'b0;
        irq_src  = '0;
        en_wr    = 1'b0;
        en_wdata = '0;
        irq_ack  = 1'b0;
        mret     = 1'b0;
        #1;
        test_reset();
        test_basic_latency();
        test_priority();
        test_enable_gate();
        test_withdraw();
        test_service_accum();
        test_async_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected codes never observed", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule : tb_interrupt_controller
`default_nettype wire
